// File: rtl/vram_write_arbiter_pkg.sv
// Shared constants and FSM encoding for the VRAM write-port arbiter.
// The optional VRAM_FILL_CLIP_EN macro suppresses writes to off-screen fill pixels.
package vram_write_arbiter_pkg;

  localparam int SCREEN_W    = 200;
  localparam int SCREEN_H    = 150;
  localparam int ADDR_W      = 15;
  localparam int VRAM_DATA_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fill_state_t;

endpackage

// File: rtl/vram_write_arbiter_if.sv
// Signal bundle between the CPU bus decode / fill launcher and the VRAM write port.
// The slave modport is the arbiter side; the master modport drives the requests.
interface vram_write_arbiter_if;
  import vram_write_arbiter_pkg::*;

  // Handshake: cpu_we_i and fill_start_i are single-cycle valid strobes with no
  // ready. A CPU store is always taken in its own cycle. A fill launch is taken
  // only while fill_busy_o is low and is silently ignored otherwise.
  logic                   cpu_we_i;
  logic [ADDR_W-1:0]      cpu_addr_i;
  logic [VRAM_DATA_W-1:0] cpu_data_i;
  logic                   fill_start_i;
  logic [7:0]             fill_x0_i;
  logic [7:0]             fill_y0_i;
  logic [7:0]             fill_w_i;
  logic [7:0]             fill_h_i;
  logic [VRAM_DATA_W-1:0] fill_color_i;
  logic                   fill_busy_o;
  logic                   fill_done_o;
  logic                   v_we_o;
  logic [ADDR_W-1:0]      v_addr_o;
  logic [VRAM_DATA_W-1:0] v_data_o;
  fill_state_t            fill_state;

  modport master (
    output cpu_we_i, cpu_addr_i, cpu_data_i,
    output fill_start_i, fill_x0_i, fill_y0_i, fill_w_i, fill_h_i, fill_color_i,
    input  fill_busy_o, fill_done_o, v_we_o, v_addr_o, v_data_o, fill_state
  );

  modport slave (
    input  cpu_we_i, cpu_addr_i, cpu_data_i,
    input  fill_start_i, fill_x0_i, fill_y0_i, fill_w_i, fill_h_i, fill_color_i,
    output fill_busy_o, fill_done_o, v_we_o, v_addr_o, v_data_o, fill_state
  );

endinterface

// File: rtl/vram_fill_engine.sv
// Rectangle-fill walker: one pixel per granted cycle, row-major, holding on stalls.
// With VRAM_FILL_CLIP_EN defined, pixels outside the screen are flagged as not to be written.
module vram_fill_engine
  import vram_write_arbiter_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [7:0]             x0,
  input  logic [7:0]             y0,
  input  logic [7:0]             w,
  input  logic [7:0]             h,
  input  logic [VRAM_DATA_W-1:0] color,
  input  logic                   grant,
  output logic                   req,
  output logic [ADDR_W-1:0]      addr,
  output logic [VRAM_DATA_W-1:0] data,
  output logic                   pix_en,
  output logic                   last,
  output logic                   zero_start,
  output fill_state_t            state
);

  fill_state_t            state_d;
  logic                   load;
  logic [8:0]             cur_x;
  logic [8:0]             x_start;
  logic [8:0]             x_end;
  logic [7:0]             cur_y_cnt;
  logic [7:0]             h_q;
  logic [VRAM_DATA_W-1:0] color_q;
  logic [ADDR_W-1:0]      row_base;
  logic [ADDR_W-1:0]      row_base_init;
  logic                   row_end;

  // Row base is only needed modulo the VRAM size, so the product is kept 15 bits wide.
  assign row_base_init = ADDR_W'(y0) * ADDR_W'(SCREEN_W);
  assign row_end       = (cur_x == x_end);
  assign last          = row_end && (cur_y_cnt == h_q - 8'd1);
  assign addr          = row_base + ADDR_W'(cur_x);
  assign data          = color_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d    = state;
    req        = 1'b0;
    load       = 1'b0;
    zero_start = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (w == 8'd0 || h == 8'd0) begin
            zero_start = 1'b1;
          end else begin
            load    = 1'b1;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        req = 1'b1;
        if (grant && last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_x     <= '0;
      x_start   <= '0;
      x_end     <= '0;
      cur_y_cnt <= '0;
      h_q       <= '0;
      color_q   <= '0;
      row_base  <= '0;
    end else if (load) begin
      cur_x     <= {1'b0, x0};
      x_start   <= {1'b0, x0};
      x_end     <= {1'b0, x0} + {1'b0, w} - 9'd1;
      cur_y_cnt <= '0;
      h_q       <= h;
      color_q   <= color;
      row_base  <= row_base_init;
    end else if (req && grant) begin
      if (row_end) begin
        cur_x     <= x_start;
        row_base  <= row_base + ADDR_W'(SCREEN_W);
        cur_y_cnt <= cur_y_cnt + 8'd1;
      end else begin
        cur_x <= cur_x + 9'd1;
      end
    end
  end

`ifdef VRAM_FILL_CLIP_EN
  logic [7:0] y0_q;
  logic [8:0] y_abs;

  always_ff @(posedge clk) begin
    if (rst)       y0_q <= '0;
    else if (load) y0_q <= y0;
  end

  assign y_abs  = {1'b0, y0_q} + {1'b0, cur_y_cnt};
  assign pix_en = (cur_x < 9'(SCREEN_W)) && (y_abs < 9'(SCREEN_H));
`else
  assign pix_en = 1'b1;
`endif

endmodule

// File: rtl/vram_write_arbiter.sv
// VRAM write port 2 owner: CPU stores take absolute priority, the fill engine uses free cycles.
// Build with VRAM_FILL_CLIP_EN to drop off-screen fill pixels.
module vram_write_arbiter
  import vram_write_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  vram_write_arbiter_if.slave  bus
);

  logic                   fill_req;
  logic                   fill_grant;
  logic                   fill_write;
  logic                   fill_pix_en;
  logic                   fill_last;
  logic                   fill_zero_start;
  logic [ADDR_W-1:0]      fill_addr;
  logic [VRAM_DATA_W-1:0] fill_data;
  fill_state_t            fill_state;

  logic                   v_we_q;
  logic [ADDR_W-1:0]      v_addr_q;
  logic [VRAM_DATA_W-1:0] v_data_q;
  logic                   done_q;

  vram_fill_engine u_fill (
    .clk        (clk),
    .rst        (rst),
    .start      (bus.fill_start_i),
    .x0         (bus.fill_x0_i),
    .y0         (bus.fill_y0_i),
    .w          (bus.fill_w_i),
    .h          (bus.fill_h_i),
    .color      (bus.fill_color_i),
    .grant      (fill_grant),
    .req        (fill_req),
    .addr       (fill_addr),
    .data       (fill_data),
    .pix_en     (fill_pix_en),
    .last       (fill_last),
    .zero_start (fill_zero_start),
    .state      (fill_state)
  );

  assign fill_grant = fill_req & ~bus.cpu_we_i;
  // A clipped pixel still consumes its grant but leaves the port idle.
  assign fill_write = fill_grant & fill_pix_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      v_we_q   <= 1'b0;
      v_addr_q <= '0;
      v_data_q <= '0;
      done_q   <= 1'b0;
    end else begin
      v_we_q <= bus.cpu_we_i | fill_write;
      if (bus.cpu_we_i) begin
        v_addr_q <= bus.cpu_addr_i;
        v_data_q <= bus.cpu_data_i;
      end else if (fill_write) begin
        v_addr_q <= fill_addr;
        v_data_q <= fill_data;
      end
      done_q <= (fill_grant & fill_last) | fill_zero_start;
    end
  end

  assign bus.v_we_o      = v_we_q;
  assign bus.v_addr_o    = v_addr_q;
  assign bus.v_data_o    = v_data_q;
  assign bus.fill_done_o = done_q;
  assign bus.fill_busy_o = (fill_state == RUN);
  assign bus.fill_state  = fill_state;

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Directed and randomized bench for vram_write_arbiter, checked against a pixel-list model.
// Define VRAM_FILL_CLIP_EN for both bench and RTL to cover the clipping build.
module tb_vram_write_arbiter;
  import vram_write_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;

  vram_write_arbiter_if bus ();

  vram_write_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Pending fill pixels in issue order: {write_enable, addr[14:0], data[7:0]}.
  logic [23:0] exp_q[$];
  logic        m_busy;
  logic [14:0] m_addr;
  logic [7:0]  m_data;
  logic [14:0] wr_log[$];
  int          busy_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void queue_fill(input logic [7:0] x0, input logic [7:0] y0,
                                     input logic [7:0] w, input logic [7:0] h,
                                     input logic [7:0] col);
    for (int r = 0; r < int'(h); r++) begin
      for (int c = 0; c < int'(w); c++) begin
        int x;
        int y;
        int a;
        logic en;
        x  = int'(x0) + c;
        y  = int'(y0) + r;
        a  = (y * SCREEN_W + x) % (1 << ADDR_W);
        en = 1'b1;
`ifdef VRAM_FILL_CLIP_EN
        en = (x < SCREEN_W) && (y < SCREEN_H);
`endif
        exp_q.push_back({en, 15'(a), col});
      end
    end
  endfunction

  task automatic cycle(input logic cwe, input logic [14:0] caddr, input logic [7:0] cdata,
                       input logic st, input logic [7:0] x0, input logic [7:0] y0,
                       input logic [7:0] w, input logic [7:0] h, input logic [7:0] col);
    logic        n_we;
    logic        n_done;
    logic        n_ad;
    logic [23:0] p;
    n_we   = 1'b0;
    n_done = 1'b0;
    n_ad   = 1'b1;
    bus.cpu_we_i     = cwe;
    bus.cpu_addr_i   = caddr;
    bus.cpu_data_i   = cdata;
    bus.fill_start_i = st;
    bus.fill_x0_i    = x0;
    bus.fill_y0_i    = y0;
    bus.fill_w_i     = w;
    bus.fill_h_i     = h;
    bus.fill_color_i = col;
    if (cwe) begin
      n_we   = 1'b1;
      m_addr = caddr;
      m_data = cdata;
    end
    if (m_busy) begin
      if (!cwe) begin
        p = exp_q.pop_front();
        if (p[23]) begin
          n_we   = 1'b1;
          m_addr = p[22:8];
          m_data = p[7:0];
        end else begin
          n_ad = 1'b0;
        end
        if (exp_q.size() == 0) begin
          m_busy = 1'b0;
          n_done = 1'b1;
        end
      end
    end else if (st) begin
      if (w == 8'd0 || h == 8'd0) begin
        n_done = 1'b1;
      end else begin
        queue_fill(x0, y0, w, h, col);
        m_busy = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (bus.v_we_o === 1'b1) wr_log.push_back(bus.v_addr_o);
    if (bus.fill_busy_o === 1'b1) busy_cnt++;
    chk("v_we", bus.v_we_o, n_we);
    if (n_ad) begin
      chk("v_addr", bus.v_addr_o, m_addr);
      chk("v_data", bus.v_data_o, m_data);
    end
    chk("fill_done", bus.fill_done_o, n_done);
    chk("fill_busy", bus.fill_busy_o, m_busy);
  endtask

  task automatic idle();
    cycle(1'b0, 15'd0, 8'd0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
  endtask

  task automatic cpu(input logic [14:0] a, input logic [7:0] d);
    cycle(1'b1, a, d, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
  endtask

  task automatic start(input logic [7:0] x0, input logic [7:0] y0, input logic [7:0] w,
                       input logic [7:0] h, input logic [7:0] col);
    cycle(1'b0, 15'd0, 8'd0, 1'b1, x0, y0, w, h, col);
  endtask

  task automatic run_until_idle(input int limit);
    int n;
    n = 0;
    while (m_busy && n < limit) begin
      idle();
      n++;
    end
    if (m_busy) chk("fill_timeout", bus.fill_busy_o, 32'd0);
  endtask

  task automatic rst_step();
    rst              = 1'b1;
    bus.cpu_we_i     = 1'b0;
    bus.fill_start_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    m_busy = 1'b0;
    m_addr = '0;
    m_data = '0;
    chk("rst_v_we", bus.v_we_o, 32'd0);
    chk("rst_v_addr", bus.v_addr_o, 32'd0);
    chk("rst_v_data", bus.v_data_o, 32'd0);
    chk("rst_done", bus.fill_done_o, 32'd0);
    chk("rst_busy", bus.fill_busy_o, 32'd0);
    chk("rst_state", bus.fill_state, IDLE);
  endtask

  initial begin
    int exp_a[4];
    int exp_b[5];
    rst              = 1'b1;
    bus.cpu_we_i     = 1'b0;
    bus.cpu_addr_i   = '0;
    bus.cpu_data_i   = '0;
    bus.fill_start_i = 1'b0;
    bus.fill_x0_i    = '0;
    bus.fill_y0_i    = '0;
    bus.fill_w_i     = '0;
    bus.fill_h_i     = '0;
    bus.fill_color_i = '0;
    busy_cnt         = 0;
    rst_step();

    // CPU store passes through with one cycle latency, then the port idles.
    cpu(15'h1234, 8'hA5);
    chk("cpu_addr_lit", bus.v_addr_o, 32'h1234);
    chk("cpu_data_lit", bus.v_data_o, 32'hA5);
    idle();

    // 2x2 fill with no CPU traffic.
    wr_log.delete();
    busy_cnt = 0;
    start(8'd3, 8'd2, 8'd2, 8'd2, 8'h3C);
    run_until_idle(20);
    idle();
    exp_a = '{403, 404, 603, 604};
    chk("fill_busy_len", busy_cnt, 32'd4);
    chk("fill_wr_count", wr_log.size(), 32'd4);
    if (wr_log.size() == 4)
      for (int i = 0; i < 4; i++) chk("fill_wr_addr", wr_log[i], exp_a[i]);

    // Same fill with a CPU store in the second RUN cycle.
    wr_log.delete();
    start(8'd3, 8'd2, 8'd2, 8'd2, 8'h3C);
    idle();
    cpu(15'h0010, 8'h77);
    run_until_idle(20);
    idle();
    exp_b = '{403, 16, 404, 603, 604};
    chk("mix_wr_count", wr_log.size(), 32'd5);
    if (wr_log.size() == 5)
      for (int i = 0; i < 5; i++) chk("mix_wr_addr", wr_log[i], exp_b[i]);

    // Zero-width fill: done pulse only.
    wr_log.delete();
    busy_cnt = 0;
    start(8'd5, 8'd5, 8'd0, 8'd5, 8'h99);
    idle();
    idle();
    chk("zero_busy", busy_cnt, 32'd0);
    chk("zero_writes", wr_log.size(), 32'd0);

    // Reset in the middle of a 10x10 fill, then a fresh launch.
    start(8'd0, 8'd0, 8'd10, 8'd10, 8'h11);
    idle();
    idle();
    idle();
    rst_step();
    idle();
    idle();
    start(8'd1, 8'd1, 8'd3, 8'd2, 8'h22);
    run_until_idle(20);
    idle();

`ifdef VRAM_FILL_CLIP_EN
    wr_log.delete();
    start(8'd198, 8'd149, 8'd4, 8'd2, 8'h5A);
    run_until_idle(20);
    idle();
    chk("clip_wr_count", wr_log.size(), 32'd2);
    if (wr_log.size() == 2) begin
      chk("clip_addr0", wr_log[0], 32'd29998);
      chk("clip_addr1", wr_log[1], 32'd29999);
    end
`endif

    // Random fills with random CPU stores and ignored relaunches while busy.
    for (int t = 0; t < 30; t++) begin
      int n;
      start(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            8'($urandom_range(0, 8)), 8'($urandom_range(0, 6)), 8'($urandom));
      n = 0;
      while (m_busy && n < 200) begin
        cycle(($urandom_range(0, 2) == 0), 15'($urandom), 8'($urandom),
              ($urandom_range(0, 5) == 0), 8'($urandom), 8'($urandom),
              8'($urandom_range(0, 4)), 8'($urandom_range(0, 4)), 8'($urandom));
        n++;
      end
      if (m_busy) chk("rand_timeout", bus.fill_busy_o, 32'd0);
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        if ($urandom_range(0, 1) == 0) idle();
        else cpu(15'($urandom), 8'($urandom));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vram_write_arbiter.md
Name: vram_write_arbiter

Overview:
Owns VRAM write port 2 (addr 15b, data 8b, we) and shares it between CPU byte stores and a hardware rectangle-fill engine. The CPU has absolute priority; the fill engine advances one pixel per free cycle. Sits between the CPU bus decode and the GPU's VRAM write inputs (v_we_i / v_addr_i / v_data_i). Frees the CPU from per-pixel loops for clears and solid boxes.

Parameters:
SCREEN_W, 200, pixels per row; the framebuffer address is y*SCREEN_W + x.
SCREEN_H, 150, rows; used only by the clip logic.
ADDR_W, 15, VRAM address width.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cpu_we_i  in  1  CPU VRAM store strobe, single cycle
cpu_addr_i  in  15  CPU store address
cpu_data_i  in  8  CPU store data
fill_start_i  in  1  launch a fill; accepted only when idle
fill_x0_i  in  8  rectangle left column
fill_y0_i  in  8  rectangle top row
fill_w_i  in  8  width in pixels
fill_h_i  in  8  height in rows
fill_color_i  in  8  fill byte
fill_busy_o  out  1  fill in progress
fill_done_o  out  1  one-cycle completion pulse
v_we_o  out  1  VRAM write enable (registered)
v_addr_o  out  15  VRAM write address (registered)
v_data_o  out  8  VRAM write data (registered)

Behaviour:
- Reset: all outputs 0; FSM = IDLE; internal counters 0. Reset during RUN aborts the fill: no further writes and no done pulse.
- Output latency: a grant decided in cycle n appears on v_* in cycle n+1. When there is no grant, v_we_o = 0 and v_addr_o / v_data_o hold their previous values.
- Arbitration: when cpu_we_i = 1, the CPU is granted unconditionally. The fill engine is granted only in RUN cycles with cpu_we_i = 0. A stalled fill holds its current pixel; it is neither lost nor duplicated. CPU stores are never dropped or delayed.
- FSM IDLE:
  - fill_start_i with w = 0 or h = 0: no writes; fill_done_o pulses in the next cycle; stay in IDLE.
  - Otherwise: latch color, w and h; set cur_x = x0 and cur_y_cnt = 0; compute row_base = y0*SCREEN_W once (one multiply, or a registered shift-add); go to RUN.
  - fill_busy_o = 1 from the next cycle.
- FSM RUN: on each fill grant, issue addr = (row_base + cur_x) mod 2^15.
  - If cur_x = x0 + w - 1: set cur_x = x0, row_base += SCREEN_W, cur_y_cnt += 1.
  - Otherwise: cur_x += 1.
  - The grant of the last pixel (cur_x = x0+w-1 and cur_y_cnt = h-1) returns the FSM to IDLE. In the following cycle, v_we_o carries the last pixel, fill_done_o = 1, and fill_busy_o = 0.
- fill_start_i while busy: ignored; the latched operands are unaffected.
- Arithmetic: x0 + w - 1 is computed 9 bits wide. Without clipping, columns beyond 255 or addresses beyond 2^15 wrap modulo; the caller is responsible for staying in bounds.
- Throughput: w*h cycles plus one cycle per CPU store during the fill.

Optional Feature:
Macro VRAM_FILL_CLIP_EN.
- Defined: a pixel with x >= SCREEN_W or y >= SCREEN_H still consumes its grant cycle but produces v_we_o = 0. Counters advance normally and done timing is unchanged.
- Undefined: no bounds check; every pixel is written at its wrapped address.

Decomposition:
- Shared gpu package/header:
  - SCREEN_W, SCREEN_H, ADDR_W
  - VRAM_DATA_W = 8
  - FSM state encoding: IDLE = 1'b0, RUN = 1'b1
- Sub-module vram_fill_engine: FSM, counters, row_base and clip logic. Outputs req/addr/data and takes a grant input.
- The top level keeps the priority mux and the output register.

Test Plan:
- CPU only: cpu_we_i=1, addr=0x1234, data=0xA5 at cycle n -> v_we_o=1, v_addr_o=0x1234, v_data_o=0xA5 at n+1, and v_we_o=0 at n+2.
- Fill x0=3, y0=2, w=2, h=2, color=0x3C with no CPU traffic -> writes at 403, 404, 603, 604 on consecutive cycles; fill_done_o pulses with the 604 write; busy spans exactly 4 cycles.
- Same fill with cpu_we_i (addr 0x0010) in the second RUN cycle -> bus order 403, 0x0010 (CPU data), 404, 603, 604; 5 write cycles total; no pixel missing or duplicated.
- Fill with w=0, h=5 -> no v_we_o; fill_done_o pulses one cycle after start; busy never asserts.
- rst asserted after 3 pixels of a 10x10 fill -> outputs 0 next cycle; no done pulse; a new start is accepted afterwards.
- With VRAM_FILL_CLIP_EN: x0=198, y0=149, w=4, h=2 -> only addresses 29998 and 29999 written; done pulses after 8 grant cycles.
